// File: rtl/constants_pkg.sv
// rtl/constants_pkg.sv - shared constants and write-back request bundle
package constants_pkg;

  localparam int REGISTER_ADDRESS_BITS = 3;
  localparam int REGISTER_DATA_BITS    = 8;
  localparam int WB_CHANNELS           = 2;

  typedef struct packed {
    logic                             valid;
    logic [REGISTER_ADDRESS_BITS-1:0] addr;
    logic [REGISTER_DATA_BITS-1:0]    data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with last-grant memory
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last_grant;

  // On a tie the channel that did not win last time is served.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - write-back arbiter and pending-write scoreboard
module regfile_wb_arbiter
  import constants_pkg::*;
#(
  parameter int ADDR_BITS = REGISTER_ADDRESS_BITS,
  parameter int DATA_BITS = REGISTER_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb0_valid,
  output logic                 wb0_ready,
  input  logic [ADDR_BITS-1:0] wb0_addr,
  input  logic [DATA_BITS-1:0] wb0_data,
  input  logic                 wb1_valid,
  output logic                 wb1_ready,
  input  logic [ADDR_BITS-1:0] wb1_addr,
  input  logic [DATA_BITS-1:0] wb1_data,
  input  logic                 rsv_valid,
  output logic                 rsv_ready,
  input  logic [ADDR_BITS-1:0] rsv_addr,
  input  logic [ADDR_BITS-1:0] rd0_addr,
  output logic                 rd0_busy,
  input  logic [ADDR_BITS-1:0] rd1_addr,
  output logic                 rd1_busy,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic                 wr_enable,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 err_unreserved
);

  localparam int NUM_REGS = 2 ** ADDR_BITS;

  wb_req_t                req [WB_CHANNELS];
  logic [WB_CHANNELS-1:0] req_valid;
  logic [WB_CHANNELS-1:0] grant;
  logic                   transfer;
  logic                   rsv_fire;
  logic                   err_set;
  logic [ADDR_BITS-1:0]   grant_addr;
  logic [DATA_BITS-1:0]   grant_data;
  logic [NUM_REGS-1:0]    busy;
  logic [NUM_REGS-1:0]    busy_next;

  // Requests are masked while reset is held so no ready leaks out.
  always_comb begin
    req[0].valid = wb0_valid && reset;
    req[0].addr  = wb0_addr;
    req[0].data  = wb0_data;
    req[1].valid = wb1_valid && reset;
    req[1].addr  = wb1_addr;
    req[1].data  = wb1_data;
    req_valid    = {req[1].valid, req[0].valid};
  end

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .grant (grant)
  );

  assign wb0_ready = grant[0];
  assign wb1_ready = grant[1];
  assign transfer  = |grant;

  always_comb begin
    grant_addr = req[0].addr;
    grant_data = req[0].data;
    if (grant[1]) begin
      grant_addr = req[1].addr;
      grant_data = req[1].data;
    end
  end

  assign rsv_fire  = reset && rsv_valid && !busy[rsv_addr];
  assign rsv_ready = rsv_fire;
  assign rd0_busy  = reset && busy[rd0_addr];
  assign rd1_busy  = reset && busy[rd1_addr];

  // A same-edge reservation of the target counts as a valid claim.
  assign err_set = transfer && !busy[grant_addr] &&
                   !(rsv_fire && (rsv_addr == grant_addr));

  // Reserve is applied after clear so it wins on the same address.
  always_comb begin
    busy_next = busy;
    if (wr_enable) begin
      busy_next[wr_addr] = 1'b0;
    end
    if (rsv_fire) begin
      busy_next[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy           <= '0;
      wr_enable      <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      err_unreserved <= 1'b0;
    end else begin
      busy      <= busy_next;
      wr_enable <= transfer;
      if (transfer) begin
        wr_addr <= grant_addr;
        wr_data <= grant_data;
      end
      if (err_set) begin
        err_unreserved <= 1'b1;
      end
    end
  end

endmodule
